// File: rtl/fsm_serial_pattern_tx.sv
// MSB-first parallel-to-serial transmitter with optional inter-word idle gap.
// Define FSM_SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit per word.
module fsm_serial_pattern_tx #(
    parameter int WIDTH = 32,
    parameter int GAP   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          ser_o,
    output logic                          ser_valid_o,
    output logic                          done_o,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt_o
);

    localparam int CW = $clog2(WIDTH + 2);
`ifdef FSM_SERIAL_PATTERN_TX_PARITY_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif
    localparam logic [CW-1:0] LEN_C = CW'(LEN);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] TWO_C = CW'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  sh, sh_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [7:0]        gap_cnt, gap_n;
    logic              ser_q, ser_n;
`ifdef FSM_SERIAL_PATTERN_TX_PARITY_EN
    logic              par, par_n;
`endif
    logic              last;
    logic              accept;

    assign last        = (state == ST_SHIFT) && (cnt == ONE_C);
    // rst gates ready so nothing can be accepted while reset is held
    assign ready_o     = !rst && ((state == ST_IDLE) || (last && (GAP == 0)));
    assign accept      = valid_i && ready_o;
    assign ser_o       = ser_q;
    assign ser_valid_o = (state == ST_SHIFT);
    assign done_o      = last;
    assign bit_cnt_o   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sh      <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
            ser_q   <= 1'b0;
`ifdef FSM_SERIAL_PATTERN_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
            gap_cnt <= gap_n;
            ser_q   <= ser_n;
`ifdef FSM_SERIAL_PATTERN_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        gap_n   = gap_cnt;
        ser_n   = ser_q;
`ifdef FSM_SERIAL_PATTERN_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            ST_IDLE: begin
                ser_n = 1'b0;
                cnt_n = '0;
            end
            ST_SHIFT: begin
                if (cnt == ONE_C) begin
                    ser_n = 1'b0;
                    cnt_n = '0;
                    if (GAP == 0) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_GAP;
                        gap_n   = 8'(GAP);
                    end
                end else begin
                    ser_n = sh[WIDTH-1];
                    sh_n  = {sh[WIDTH-2:0], 1'b0};
                    cnt_n = cnt - ONE_C;
`ifdef FSM_SERIAL_PATTERN_TX_PARITY_EN
                    if (cnt == TWO_C) ser_n = par;
`endif
                end
            end
            ST_GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_n = ST_IDLE;
                    gap_n   = 8'd0;
                end else begin
                    gap_n = gap_cnt - 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // sh keeps the bits still to send; the MSB goes straight to ser_q
        if (accept) begin
            state_n = ST_SHIFT;
            ser_n   = data_i[WIDTH-1];
            sh_n    = {data_i[WIDTH-2:0], 1'b0};
            cnt_n   = LEN_C;
`ifdef FSM_SERIAL_PATTERN_TX_PARITY_EN
            par_n   = ^data_i;
`endif
        end
    end

    logic unused_two;
    assign unused_two = ^TWO_C;

endmodule

// File: doc/fsm_serial_pattern_tx.md
Name: fsm_serial_pattern_tx

Overview:
Parallel-to-serial bit-stream transmitter that drives the single-bit input of the serial pattern-detector FSMs.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk.
- Supports configurable idle gap cycles between words, or back-to-back streaming when the gap is zero.
- Used as the stimulus source in front of the Mealy/Moore detectors on the board and in system sims.

Parameters:
- WIDTH, 32, word length in bits (2..64).
- GAP, 0, idle cycles inserted after each word (0..255); GAP=0 allows back-to-back words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  word to transmit; bit WIDTH-1 is sent first.
- valid_i  input  1  data_i valid; a word is accepted when valid_i && ready_o at a rising edge.
- ready_o  output  1  transmitter can accept a word this cycle.
- ser_o  output  1  serial bit; connects to the detector in_i.
- ser_valid_o  output  1  ser_o carries a payload bit this cycle.
- done_o  output  1  one-cycle pulse coincident with the final bit of a word.
- bit_cnt_o  output  $clog2(WIDTH+2)  bits remaining, including the current bit; 0 when idle.

Behaviour:
- Single clock clk; reset rst is asynchronous, active-high. Reset forces:
  - state to IDLE;
  - ser_o=0, ser_valid_o=0, done_o=0, bit_cnt_o=0;
  - shift register and gap counter to 0;
  - ready_o=0 while rst is high.
- First cycle after rst deasserts: ready_o=1.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ready_o=1, ser_o=0, ser_valid_o=0.
  - On accept at edge N: load the shift register, go to SHIFT, bit_cnt_o=WIDTH.
- SHIFT:
  - ser_valid_o=1; ser_o = data_i[WIDTH-1-k] during cycle N+k, for k=0..WIDTH-1.
  - Latency: the first bit is visible in the cycle immediately after the accept edge.
  - Each bit is held exactly one clk. bit_cnt_o decrements by 1 per edge.
  - data_i is ignored after the accept edge (captured copy only).
- Final bit (bit_cnt_o==1):
  - done_o=1 for that cycle only.
  - ready_o=1 only if GAP==0; an accept on that edge reloads and continues SHIFT with no bubble.
  - Otherwise, with GAP==0, go to IDLE; with GAP>0, go to GAP.
- GAP:
  - ser_valid_o=0, ser_o=0, ready_o=0 for exactly GAP cycles, then IDLE.
- ready_o is combinational from state and counters, never from valid_i.
- valid_i while ready_o=0 has no effect; the source must hold the word until accepted.
- Reset asserted mid-word: the word is abandoned immediately, with no done_o pulse and no partial resume.
- ser_o is registered (glitch-free) and changes only after rising edges, so a downstream detector on the same clk samples each bit once.

Optional Feature:
- Macro: FSM_SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - After bit 0, one extra bit is sent with ser_valid_o=1: the even-parity bit (XOR of all WIDTH data bits).
  - bit_cnt_o loads WIDTH+1.
  - done_o and the GAP==0 back-to-back ready_o move to the parity cycle.
  - A word occupies WIDTH+1 cycles.
- Undefined: no parity bit; exactly WIDTH payload cycles per word.

Test Plan:
- Basic word: WIDTH=32, GAP=0, single accept of 32'hFDCAE398 → ser_o sequence 1111_1101_1100_1010_1110_0011_1001_1000 over 32 consecutive cycles with ser_valid_o=1; done_o only on the 32nd; bit_cnt_o counts 32→1 then 0; ready_o=1 the cycle after.
- Back-to-back: WIDTH=8, GAP=0, valid_i held high with 8'hA5 then 8'h3C → 16 contiguous valid bits 10100101_00111100; ready_o high on cycle 8; no idle bubble.
- Gap: WIDTH=8, GAP=3, two words 8'hFF and 8'h01 → 8 ones, 3 cycles with ser_valid_o=0 and ready_o=0, 1 IDLE cycle with ready_o=1, then 00000001.
- Mid-word reset: rst pulsed asynchronously after bit 10 of 32'hFDCAE398 → all outputs 0 immediately (before the next edge); no done_o; next accept of 32'h00000001 transmits cleanly from its MSB.
- Backpressure: valid_i asserted during SHIFT (GAP=2) with data_i changing every cycle → in-flight bits unaffected; the new word is captured only at the first IDLE ready edge.
- Parity (FSM_SERIAL_PATTERN_TX_PARITY_EN defined): 32'hFDCAE398 (popcount 19) → 33 valid bits, 33rd bit =1, done_o on bit 33; 8'hA5 (popcount 4) → 9th bit =0.
